// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared register-file definitions for the npc integer register file and its
// write-port scheduler.
package regfile_wb_ctrl_pkg;

  localparam logic RST_VAL      = 1'b0;
  localparam int   REG_BUS_W    = 32;
  localparam int   REG_ADDR_W   = 5;
  localparam int   REG_NUM      = 32;
  localparam int   REG0         = 0;
  localparam int   LQ_DEPTH_DEF = 4;

endpackage

// File: rtl/wb_tag_fifo.sv
// In-order FIFO of load destination tags; exposes raw entries plus a valid
// mask so the owner can build a scoreboard without extra state.
module wb_tag_fifo
  import regfile_wb_ctrl_pkg::*;
#(
  parameter  int ADDR_W = REG_ADDR_W,
  parameter  int DEPTH  = LQ_DEPTH_DEF,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [ADDR_W-1:0]              push_rd,
  input  logic                           pop,
  output logic [DEPTH-1:0][ADDR_W-1:0]   entries,
  output logic [DEPTH-1:0]               vmask,
  output logic [ADDR_W-1:0]              head_rd,
  output logic [CNT_W-1:0]               count
);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // Entry contents need no reset: vmask hides anything stale.
  always_ff @(posedge clk) begin
    if (rst == RST_VAL) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_rd;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [PTR_W-1:0] off;
    assign off      = PTR_W'(i) - rd_ptr;
    assign vmask[i] = CNT_W'(off) < count;
  end

  assign head_rd = entries[rd_ptr];

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Single write-port scheduler: load responses win over ALU results, ALU writes
// wait on outstanding loads to the same rd, and decode stalls on pending writes.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter  int DATA_W   = REG_BUS_W,
  parameter  int ADDR_W   = REG_ADDR_W,
  parameter  int LQ_DEPTH = LQ_DEPTH_DEF,
  localparam int CNT_W    = $clog2(LQ_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_issue_valid,
  input  logic [ADDR_W-1:0] ld_issue_rd,
  output logic              ld_issue_ready,
  input  logic              ld_resp_valid,
  input  logic [DATA_W-1:0] ld_resp_data,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              hazard_stall,
  output logic              wb_wen,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  lq_count,
  output logic              resp_err
);

  localparam int NREG = 1 << ADDR_W;

  logic [LQ_DEPTH-1:0][ADDR_W-1:0] entries;
  logic [LQ_DEPTH-1:0]             vmask;
  logic [ADDR_W-1:0]               head_rd;
  logic                            ld_pop, ld_push;
  logic [NREG-1:0]                 busy;

  assign ld_pop         = ld_resp_valid && (lq_count != '0);
  assign ld_issue_ready = (lq_count < CNT_W'(LQ_DEPTH)) || ld_pop;
  assign ld_push        = ld_issue_valid && ld_issue_ready;

  wb_tag_fifo #(.ADDR_W(ADDR_W), .DEPTH(LQ_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (ld_push),
    .push_rd (ld_issue_rd),
    .pop     (ld_pop),
    .entries (entries),
    .vmask   (vmask),
    .head_rd (head_rd),
    .count   (lq_count)
  );

  // Duplicate tags simply OR together, so a register stays busy until its
  // last outstanding load retires.
  always_comb begin
    busy = '0;
    for (int i = 0; i < LQ_DEPTH; i++)
      if (vmask[i]) busy[entries[i]] = 1'b1;
    busy[REG0] = 1'b0;
  end

  assign alu_ready = alu_valid && !ld_resp_valid && !busy[alu_rd];

  logic              sel_vld;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    sel_vld  = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    if (ld_pop) begin
      sel_vld  = 1'b1;
      sel_rd   = head_rd;
      sel_data = ld_resp_data;
    end else if (alu_ready) begin
      sel_vld  = 1'b1;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  // x0 writes are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst == RST_VAL) begin
      wb_wen   <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      resp_err <= 1'b0;
    end else begin
      wb_wen <= sel_vld && (sel_rd != ADDR_W'(REG0));
      if (sel_vld && (sel_rd != ADDR_W'(REG0))) begin
        wb_rd   <= sel_rd;
        wb_data <= sel_data;
      end
      if (ld_resp_valid && (lq_count == '0)) resp_err <= 1'b1;
    end
  end

  logic [1:0][ADDR_W-1:0] srcs;
  logic [1:0]             src_hit;

  assign srcs = {rs2, rs1};

  for (genvar s = 0; s < 2; s++) begin : g_src
    assign src_hit[s] = (srcs[s] != ADDR_W'(REG0)) &&
                        (busy[srcs[s]] || (wb_wen && (wb_rd == srcs[s])));
  end

  assign hazard_stall = |src_hit;

endmodule
